// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared pipeline definitions for the F-stage fetch controller: FSM states and fetch constants.
// Used by pc_fetch_ctrl, fetch_hold_buf and their testbench.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bus bundle: hazard/redirect inputs, imem req/ack port and the F/D register outputs.
// Optional fd_adel signal exists only when FETCH_ADEL_EN is defined.
interface pc_fetch_ctrl_if #(
    parameter int ADDR_W = 32
);

    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              fd_valid;
    logic [ADDR_W-1:0] fd_pc;
    logic [31:0]       fd_instr;
`ifdef FETCH_ADEL_EN
    logic              fd_adel;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, fd_valid, fd_pc, fd_instr, fd_adel
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, fd_valid, fd_pc, fd_instr, fd_adel
    );
`else
    modport master (
        input  stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, fd_valid, fd_pc, fd_instr
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, fd_valid, fd_pc, fd_instr
    );
`endif

endinterface

// File: rtl/pc_fetch_ctrl_hold_buf.sv
// One-entry {pc, instr} buffer that parks an instruction acked while the pipeline is stalled.
module fetch_hold_buf
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [31:0]       instr_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       instr_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;

    // Load wins over clear; the controller never requests both in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= INSTR_NOP;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// F-stage PC register and fetch sequencer with delay-slot-preserving redirects.
// Define FETCH_ADEL_EN to flag misaligned PCs via fd_adel instead of forcing PC[1:0] to zero.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input logic             clk,
    input logic             reset,
    pc_fetch_ctrl_if.master bus
);

`ifdef FETCH_ADEL_EN
    localparam logic [ADDR_W-1:0] LOAD_MASK = '1;
`else
    localparam logic [ADDR_W-1:0] LOAD_MASK = ~ADDR_W'(3);
`endif
    localparam logic [ADDR_W-1:0] RESET_PC_EFF = RESET_PC & LOAD_MASK;

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic              fd_valid_q;
    logic [ADDR_W-1:0] fd_pc_q;
    logic [31:0]       fd_instr_q;

    logic              misaligned;
    logic              deliverMem, deliverBuf, deliverAdel, advance, captureBuf;
    logic              bufValid;
    logic [ADDR_W-1:0] bufPc;
    logic [31:0]       bufInstr;

`ifdef FETCH_ADEL_EN
    logic fd_adel_q;
    assign misaligned  = (pc_q[1:0] != 2'b00);
    assign bus.fd_adel = fd_adel_q;
`else
    assign misaligned = 1'b0;
`endif

    assign bus.imem_req  = (state_q == REQ) && !misaligned;
    assign bus.imem_addr = pc_q;
    assign bus.fd_valid  = fd_valid_q;
    assign bus.fd_pc     = fd_pc_q;
    assign bus.fd_instr  = fd_instr_q;

    fetch_hold_buf #(.ADDR_W(ADDR_W)) u_hold_buf (
        .clk     (clk),
        .reset   (reset),
        .load_i  (captureBuf),
        .clear_i (deliverBuf),
        .pc_i    (pc_q),
        .instr_i (bus.imem_rdata),
        .valid_o (bufValid),
        .pc_o    (bufPc),
        .instr_o (bufInstr)
    );

    // A redirect that cannot be applied yet is parked so the delay-slot fetch still completes.
    always_comb begin
        deliverMem   = (state_q == REQ) && !misaligned && bus.imem_ack && !bus.stall;
        deliverBuf   = (state_q == HOLD) && bufValid && !bus.stall;
        deliverAdel  = (state_q == REQ) && misaligned && !bus.stall;
        captureBuf   = (state_q == REQ) && !misaligned && bus.imem_ack && bus.stall;
        advance      = deliverMem || deliverBuf || deliverAdel;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        if (advance) begin
            if (bus.redirect_valid) begin
                pc_d = bus.redirect_pc & LOAD_MASK;
            end else if (pend_valid_q) begin
                pc_d = pend_pc_q;
            end else begin
                pc_d = pc_q + ADDR_W'(4);
            end
            pend_valid_d = 1'b0;
        end else if (bus.redirect_valid && !bus.stall) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = bus.redirect_pc & LOAD_MASK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC_EFF;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    // FSM and F/D register; a stalled pipeline freezes fd_*, otherwise a non-delivery is a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fd_valid_q <= 1'b0;
            fd_pc_q    <= RESET_PC_EFF;
            fd_instr_q <= INSTR_NOP;
`ifdef FETCH_ADEL_EN
            fd_adel_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE:    state_q <= REQ;
                REQ:     if (captureBuf) state_q <= HOLD;
                HOLD:    if (!bus.stall) state_q <= REQ;
                default: state_q <= IDLE;
            endcase
            if (advance) begin
                fd_valid_q <= 1'b1;
                fd_pc_q    <= deliverBuf ? bufPc : pc_q;
                if (deliverMem) begin
                    fd_instr_q <= bus.imem_rdata;
                end else if (deliverBuf) begin
                    fd_instr_q <= bufInstr;
                end else begin
                    fd_instr_q <= INSTR_NOP;
                end
`ifdef FETCH_ADEL_EN
                fd_adel_q  <= deliverAdel;
`endif
            end else if (!bus.stall) begin
                fd_valid_q <= 1'b0;
`ifdef FETCH_ADEL_EN
                fd_adel_q  <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: an instruction-stream model predicts deliveries and fetch addresses.
// Works with or without FETCH_ADEL_EN.
module tb_pc_fetch_ctrl;
    import pc_fetch_ctrl_pkg::*;

`ifdef FETCH_ADEL_EN
    localparam logic [31:0] LOAD_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] LOAD_MASK = 32'hFFFF_FFFC;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.ADDR_W(32)) bus ();

    pc_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fd_t expQ[$];
    int  testsRun = 0;
    int  testsFailed = 0;

    // Instruction stream model: where fetch points next, what is parked, which target is pending.
    bit          mStarted, mHolding, mPendValid;
    logic [31:0] mPc, mPendPc, mBufPc, mBufInstr;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit mMisaligned();
`ifdef FETCH_ADEL_EN
        return mPc[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mStarted   = 1'b0;
        mHolding   = 1'b0;
        mPendValid = 1'b0;
        mPc        = 32'h0000_3000;
        mPendPc    = 32'h0;
        mBufPc     = 32'h0;
        mBufInstr  = 32'h0;
        expQ.delete();
    endtask

    // Called at a falling edge: checks the fetch port, drives one cycle of inputs, advances the model.
    task automatic applyStimulus(input bit st, input bit wantAck, input bit rv, input logic [31:0] rpc);
        bit  expReq, ack, adv;
        fd_t item;
        expReq = mStarted && !mHolding && !mMisaligned();
        checkOutput("imem_req", 32'(bus.imem_req), 32'(expReq));
        if (expReq) checkOutput("imem_addr", bus.imem_addr, mPc);
        ack = expReq && wantAck;
        bus.stall          = st;
        bus.imem_ack       = ack;
        bus.imem_rdata     = ack ? memWord(mPc) : 32'hDEAD_BEEF;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        adv = 1'b0;
        if (!mStarted) begin
            mStarted = 1'b1;
        end else if (mHolding) begin
            if (!st) begin
                item = '{pc: mBufPc, instr: mBufInstr, adel: 1'b0};
                expQ.push_back(item);
                mHolding = 1'b0;
                adv = 1'b1;
            end
        end else if (mMisaligned()) begin
            if (!st) begin
                item = '{pc: mPc, instr: INSTR_NOP, adel: 1'b1};
                expQ.push_back(item);
                adv = 1'b1;
            end
        end else if (ack) begin
            if (!st) begin
                item = '{pc: mPc, instr: memWord(mPc), adel: 1'b0};
                expQ.push_back(item);
                adv = 1'b1;
            end else begin
                mHolding  = 1'b1;
                mBufPc    = mPc;
                mBufInstr = memWord(mPc);
            end
        end
        if (adv) begin
            mPc = rv ? (rpc & LOAD_MASK) : (mPendValid ? mPendPc : mPc + 32'd4);
            mPendValid = 1'b0;
        end else if (rv && !st) begin
            mPendValid = 1'b1;
            mPendPc    = rpc & LOAD_MASK;
        end
        @(negedge clk);
    endtask

    task automatic randomStimulus(input int cycles);
        logic [31:0] target;
        for (int i = 0; i < cycles; i++) begin
            target = 32'h0000_3000 + ($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 15) == 0) target = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 7) == 0) target = target | 32'($urandom_range(1, 3));
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 7) == 0, target);
        end
    endtask

    // Monitor: every non-stalled edge either delivers the oldest predicted instruction or a bubble.
    initial begin
        bit  stAt, rstAt;
        fd_t item;
        forever begin
            @(posedge clk);
            stAt  = bus.stall;
            rstAt = reset;
            #1;
            if (!rstAt && !reset && !stAt) begin
                if (expQ.size() != 0) begin
                    item = expQ.pop_front();
                    checkOutput("fd_valid", 32'(bus.fd_valid), 32'd1);
                    checkOutput("fd_pc", bus.fd_pc, item.pc);
                    checkOutput("fd_instr", bus.fd_instr, item.instr);
`ifdef FETCH_ADEL_EN
                    checkOutput("fd_adel", 32'(bus.fd_adel), 32'(item.adel));
`endif
                end else begin
                    checkOutput("fd_bubble", 32'(bus.fd_valid), 32'd0);
                end
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_imem_req"}, 32'(bus.imem_req), 32'd0);
        checkOutput({tag, "_fd_valid"}, 32'(bus.fd_valid), 32'd0);
        checkOutput({tag, "_fd_pc"}, bus.fd_pc, 32'h0000_3000);
        checkOutput({tag, "_fd_instr"}, bus.fd_instr, INSTR_NOP);
`ifdef FETCH_ADEL_EN
        checkOutput({tag, "_fd_adel"}, 32'(bus.fd_adel), 32'd0);
`endif
    endtask

    initial begin
        bus.stall          = 1'b0;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        modelReset();
        repeat (2) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;

        // Back-to-back fetches at zero wait.
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        // Ack delayed three cycles.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        // Stall in the ack cycle, held two cycles, then the parked instruction drains.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        // Redirect while the delay-slot fetch waits for its ack.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_3100);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        // Redirect coinciding with ack, and a second redirect overwriting a pending one.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_3200);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_3300);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_3400);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        // Redirect under stall is ignored.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_3500);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        // Wrap past the top of the address space.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        // Misaligned target: flagged with FETCH_ADEL_EN, forced aligned otherwise.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_3102);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

        randomStimulus(1500);

        // Asynchronous reset with a fetch outstanding.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        #1;
        checkResetState("midreset");
        modelReset();
        bus.stall          = 1'b0;
        bus.imem_ack       = 1'b0;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        randomStimulus(300);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("scoreboard_drain", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
